obs_split_issue_142bit: RTL and testbench

Front end of the 142-bit OBS multiplier; the counterpart of the overlap (recombination) stage. Accepts two 142-bit GF(2) polynomial operands and splits each into even/odd coefficient halves (71 bits each). Issues the four half-products to one shared 71-bit sub-multiplier, one at a time, and collects the four 141-bit partial products. Presents them, held stable, to the overlap stage under a valid/ready handshake.

---
 rtl/obs_split_issue_142bit_pkg.sv | 11 +
 rtl/obs_split_issue_142bit_split.sv | 13 +
 rtl/obs_split_issue_142bit.sv | 127 ++++++++++++
 tb/tb_obs_split_issue_142bit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obs_split_issue_142bit_pkg.sv
// Shared constants and types for the 142-bit OBS multiplier front end.
package obs_pkg_142;
  localparam int N  = 142;
  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Selects which half-product is in flight: bit 1 picks Ao over Ae, bit 0 picks Bo over Be.
  typedef logic [1:0] idx_t;
endpackage

// File: rtl/obs_split_issue_142bit_split.sv
// Even/odd coefficient deinterleave of one N-bit GF(2) polynomial.
module obs_operand_split_142bit
  import obs_pkg_142::*;
(
  input  logic [N-1:0] i_op,
  output logic [H-1:0] o_even,
  output logic [H-1:0] o_odd
);
  for (genvar gi = 0; gi < H; gi++) begin : g_split
    assign o_even[gi] = i_op[2*gi];
    assign o_odd[gi]  = i_op[2*gi+1];
  end
endmodule

// File: rtl/obs_split_issue_142bit.sv
// Splits two 142-bit operands into halves and issues the four half-products
// to a shared 71-bit sub-multiplier, one at a time, then holds the results.
module obs_split_issue_142bit
  import obs_pkg_142::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          sm_req_valid,
  input  logic          sm_req_ready,
  output logic [H-1:0]  sm_a,
  output logic [H-1:0]  sm_b,
  input  logic          sm_rsp_valid,
  input  logic [PW-1:0] sm_rsp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] pp1,
  output logic [PW-1:0] pp2,
  output logic [PW-1:0] pp3,
  output logic [PW-1:0] pp4,
  output logic          err
);
  state_t        r_state;
  state_t        w_state_nxt;
  idx_t          r_k;
  idx_t          w_k_inc;
  logic [H-1:0]  w_ae, w_ao, w_be, w_bo;
  logic [H-1:0]  r_ae, r_ao, r_be, r_bo;
  logic [H-1:0]  r_sm_a, r_sm_b;
  logic [PW-1:0] r_pp1, r_pp2, r_pp3, r_pp4;
  logic          r_err;
  logic          w_accept;
  logic          w_rsp_take;

  obs_operand_split_142bit u_split_a (
    .i_op   (a_in),
    .o_even (w_ae),
    .o_odd  (w_ao)
  );

  obs_operand_split_142bit u_split_b (
    .i_op   (b_in),
    .o_even (w_be),
    .o_odd  (w_bo)
  );

  assign w_accept   = in_valid & (r_state == IDLE);
  assign w_rsp_take = sm_rsp_valid & (r_state == WAIT);
  assign w_k_inc    = r_k + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)     w_state_nxt = REQ;
      REQ:     if (sm_req_ready) w_state_nxt = WAIT;
      WAIT:    if (sm_rsp_valid) w_state_nxt = (r_k == 2'd3) ? DONE : REQ;
      DONE:    if (out_ready)    w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // in_ready is masked by rst so it reads low for the whole reset window.
  always_comb begin
    in_ready     = (r_state == IDLE) & ~rst;
    sm_req_valid = (r_state == REQ);
    out_valid    = (r_state == DONE);
  end

  // Request operands are registered one step ahead so they are already valid on entry to REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ae   <= '0;
      r_ao   <= '0;
      r_be   <= '0;
      r_bo   <= '0;
      r_sm_a <= '0;
      r_sm_b <= '0;
      r_k    <= '0;
      r_pp1  <= '0;
      r_pp2  <= '0;
      r_pp3  <= '0;
      r_pp4  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ae   <= w_ae;
        r_ao   <= w_ao;
        r_be   <= w_be;
        r_bo   <= w_bo;
        r_sm_a <= w_ae;
        r_sm_b <= w_be;
        r_k    <= 2'd0;
      end
      if (w_rsp_take) begin
        unique case (r_k)
          2'd0:    r_pp1 <= sm_rsp;
          2'd1:    r_pp2 <= sm_rsp;
          2'd2:    r_pp3 <= sm_rsp;
          default: r_pp4 <= sm_rsp;
        endcase
        if (r_k != 2'd3) begin
          r_k    <= w_k_inc;
          r_sm_a <= w_k_inc[1] ? r_ao : r_ae;
          r_sm_b <= w_k_inc[0] ? r_bo : r_be;
        end
      end
      // Any response outside WAIT is dropped and flagged until reset.
      if (sm_rsp_valid && (r_state != WAIT)) r_err <= 1'b1;
    end
  end

  assign sm_a = r_sm_a;
  assign sm_b = r_sm_b;
  assign pp1  = r_pp1;
  assign pp2  = r_pp2;
  assign pp3  = r_pp3;
  assign pp4  = r_pp4;
  assign err  = r_err;
endmodule

// File: tb/tb_obs_split_issue_142bit.sv
// Scoreboard bench: a sub-multiplier model answers requests, a monitor checks the held partial products.
module tb_obs_split_issue_142bit;
  import obs_pkg_142::*;

  typedef struct {
    logic [H-1:0] a;
    logic [H-1:0] b;
  } req_t;

  typedef struct {
    logic [PW-1:0] p1;
    logic [PW-1:0] p2;
    logic [PW-1:0] p3;
    logic [PW-1:0] p4;
  } pp_t;

  logic          clk, rst, in_valid, in_ready;
  logic [N-1:0]  a_in, b_in;
  logic          sm_req_valid, sm_req_ready;
  logic [H-1:0]  sm_a, sm_b;
  logic          sm_rsp_valid;
  logic [PW-1:0] sm_rsp;
  logic          out_valid, out_ready;
  logic [PW-1:0] pp1, pp2, pp3, pp4;
  logic          err;

  req_t exp_req[$];
  pp_t  exp_pp[$];
  pp_t  last_pp;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   last_hs_k = -1;
  int   last_hs_cyc = -10;
  int   stray_req = 0;
  int   stall_req = 0;
  int   hold_req = 0;

  obs_split_issue_142bit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .sm_req_valid (sm_req_valid),
    .sm_req_ready (sm_req_ready),
    .sm_a         (sm_a),
    .sm_b         (sm_b),
    .sm_rsp_valid (sm_rsp_valid),
    .sm_rsp       (sm_rsp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pp1          (pp1),
    .pp2          (pp2),
    .pp3          (pp3),
    .pp4          (pp4),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] clmul(input logic [H-1:0] a, input logic [H-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++)
      if (a[i]) r = r ^ ({{(PW-H){1'b0}}, b} << i);
    return r;
  endfunction

  function automatic logic [H-1:0] bits_at(input logic [N-1:0] x, input int off);
    logic [H-1:0] r;
    for (int i = 0; i < H; i++) r[i] = x[2*i+off];
    return r;
  endfunction

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [PW-1:0] e1, input logic [PW-1:0] e2,
                       input logic [PW-1:0] e3, input logic [PW-1:0] e4,
                       input bit push_pp);
    bit   ok;
    req_t r;
    pp_t  p;
    logic [H-1:0] ae, ao, be, bo;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 0, 1);
    ae = bits_at(a, 0); ao = bits_at(a, 1);
    be = bits_at(b, 0); bo = bits_at(b, 1);
    r.a = ae; r.b = be; exp_req.push_back(r);
    r.a = ae; r.b = bo; exp_req.push_back(r);
    r.a = ao; r.b = be; exp_req.push_back(r);
    r.a = ao; r.b = bo; exp_req.push_back(r);
    if (push_pp) begin
      p.p1 = e1; p.p2 = e2; p.p3 = e3; p.p4 = e4;
      exp_pp.push_back(p);
    end
    a_in = a; b_in = b; in_valid = 1'b1; t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_pp.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  // Sub-multiplier model: one-cycle latency, optional stall at k = 2, optional stray pulse.
  initial begin
    int    stall_left;
    int    stall_seen;
    int    stray_seen;
    bit    pending;
    logic [PW-1:0] pend_val;
    req_t  r;
    stall_left = 0; stall_seen = 0; stray_seen = 0; pending = 1'b0; pend_val = '0;
    sm_req_ready = 1'b0; sm_rsp_valid = 1'b0; sm_rsp = '0;
    forever begin
      @(negedge clk);
      sm_rsp_valid = 1'b0;
      sm_rsp       = '0;
      if (pending) begin
        sm_rsp_valid = 1'b1;
        sm_rsp       = pend_val;
        pending      = 1'b0;
      end else if (stray_seen != stray_req) begin
        stray_seen   = stray_req;
        sm_rsp_valid = 1'b1;
        sm_rsp       = '1;
      end
      sm_req_ready = 1'b1;
      if (sm_req_valid && !rst) begin
        if (exp_req.size() == 2 && stall_seen != stall_req) begin
          stall_left = 5;
          stall_seen = stall_req;
        end
        if (stall_left > 0) begin
          sm_req_ready = 1'b0;
          stall_left--;
          chk("stall_sm_a", sm_a, exp_req[0].a);
          chk("stall_sm_b", sm_b, exp_req[0].b);
        end else if (exp_req.size() == 0) begin
          chk("unexpected_req", 0, 1);
        end else begin
          r = exp_req.pop_front();
          chk("req_sm_a", sm_a, r.a);
          chk("req_sm_b", sm_b, r.b);
          pending     = 1'b1;
          pend_val    = clmul(sm_a, sm_b);
          last_hs_k   = 3 - exp_req.size();
          last_hs_cyc = cyc;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on each out_valid/out_ready handshake.
  initial begin
    int  hold_left;
    int  hold_seen;
    bit  chk_next;
    pp_t e;
    hold_left = 0; hold_seen = 0; chk_next = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        chk("in_ready_after_out", in_ready, 1);
        chk_next = 1'b0;
      end
      if (rst) begin
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (hold_seen != hold_req) begin
          hold_left = 10;
          hold_seen = hold_req;
        end
        if (exp_pp.size() == 0) begin
          chk("unexpected_out", 0, 1);
          out_ready = 1'b1;
        end else if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
          chk("hold_pp1", pp1, exp_pp[0].p1);
          chk("hold_pp2", pp2, exp_pp[0].p2);
          chk("hold_pp3", pp3, exp_pp[0].p3);
          chk("hold_pp4", pp4, exp_pp[0].p4);
          chk("hold_in_ready", in_ready, 0);
        end else begin
          out_ready = 1'b1;
          e = exp_pp.pop_front();
          chk("pp1", pp1, e.p1);
          chk("pp2", pp2, e.p2);
          chk("pp3", pp3, e.p3);
          chk("pp4", pp4, e.p4);
          last_pp  = e;
          chk_next = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    logic [N-1:0]  ones;
    logic [PW-1:0] emask;
    int  lat;
    bit  found;
    ones = '1;
    emask = '0;
    for (int j = 0; j < PW; j += 2) emask[j] = 1'b1;
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sm_req_valid", sm_req_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_pp1", pp1, 0);
    chk("rst_sm_a", sm_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    issue(142'd1, 142'd1, 141'd1, 141'd0, 141'd0, 141'd0, 1'b1);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    chk("latency", lat, 9);

    issue(142'd2, 142'd2, 141'd0, 141'd0, 141'd0, 141'd1, 1'b1);
    issue(142'd3, 142'd1, 141'd1, 141'd0, 141'd1, 141'd0, 1'b1);
    issue(142'd2, 142'd1, 141'd0, 141'd0, 141'd1, 141'd0, 1'b1);
    stall_req++;
    issue(ones, ones, emask, emask, emask, emask, 1'b1);
    hold_req++;
    wait_idle();

    stray_req++;
    repeat (3) @(negedge clk);
    chk("stray_err", err, 1);
    chk("stray_pp1", pp1, last_pp.p1);
    chk("stray_pp2", pp2, last_pp.p2);
    chk("stray_pp3", pp3, last_pp.p3);
    chk("stray_pp4", pp4, last_pp.p4);
    issue(142'd2, 142'd2, 141'd0, 141'd0, 141'd0, 141'd1, 1'b1);
    wait_idle();
    chk("err_sticky", err, 1);

    issue(142'd3, 142'd1, '0, '0, '0, '0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (last_hs_k == 1 && cyc == last_hs_cyc + 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) chk("abort_wait_timeout", 0, 1);
    rst = 1'b1;
    #1;
    chk("abort_pp1", pp1, 0);
    chk("abort_pp2", pp2, 0);
    chk("abort_pp3", pp3, 0);
    chk("abort_pp4", pp4, 0);
    chk("abort_sm_a", sm_a, 0);
    chk("abort_sm_b", sm_b, 0);
    chk("abort_sm_req_valid", sm_req_valid, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_err", err, 0);
    chk("abort_in_ready", in_ready, 0);
    exp_req.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_in_ready", in_ready, 1);
    chk("post_abort_err", err, 0);
    issue(142'd1, 142'd1, 141'd1, 141'd0, 141'd0, 141'd0, 1'b1);
    wait_idle();
    chk("final_err", err, 0);
    chk("final_req_queue", exp_req.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
